// File: rtl/add_serial.sv
// ============================================================================
// Module   : add_serial
// Brief    : Bit-serial WIDTH-bit adder driving a single add_1bit full adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT,
    output logic             OVF
);

    localparam int            CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_bit;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    // Bit 0 of the working result would only ever be shifted out, so it is not kept.
    logic [WIDTH-1:1]   s_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               z_bit;
    logic               cout_bit;
    logic [WIDTH-1:0]   s_next;

    add_1bit u_add_1bit (
        .X     (a_sr[0]),
        .Y     (b_sr[0]),
        .C_IN  (carry),
        .Z     (z_bit),
        .C_OUT (cout_bit)
    );

    assign s_next = {z_bit, s_sr};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last_bit  = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            C_OUT <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sr  <= A;
                b_sr  <= B;
                carry <= C_IN;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                s_sr  <= s_next[WIDTH-1:1];
                carry <= cout_bit;
                cnt   <= cnt + CNT_W'(1);
            end
            // On the last bit, carry still holds the carry into the MSB.
            if (last_bit) begin
                SUM   <= s_next;
                C_OUT <= cout_bit;
                OVF   <= carry ^ cout_bit;
            end
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

endmodule

// ============================================================================
// Module   : add_1bit
// Brief    : Single-bit full adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module add_1bit (
    input  logic X,
    input  logic Y,
    input  logic C_IN,
    output logic Z,
    output logic C_OUT
);

    assign Z     = X ^ Y ^ C_IN;
    assign C_OUT = (X & Y) | (X & C_IN) | (Y & C_IN);

endmodule

`default_nettype wire

// File: tb/tb_add_serial.sv
// ============================================================================
// Module   : tb_add_serial
// Brief    : Directed self-checking bench for add_serial (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] last_exp_sum = 8'h00;

    add_serial #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .C_IN  (c_in),
        .BUSY  (busy),
        .DONE  (done),
        .SUM   (sum),
        .C_OUT (c_out),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle START pulse; checks latency, BUSY length, SUM hold and results.
    task automatic do_add(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic [7:0] es, input logic ec, input logic eo);
        int edges;
        int busy_cnt;
        int unstable;
        a = ia; b = ib; c_in = ic; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0; busy_cnt = 0; unstable = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            if (sum !== last_exp_sum) unstable++;
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_sum_hold"}, unstable, 0);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, ec);
        check({tag, "_ovf"}, ovf, eo);
        last_exp_sum = es;
        tick();
    endtask

    initial begin
        int edges;
        int dones;
        int gap;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);

        do_add("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_add("ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add("80_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_add("7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add("a5_5a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Inputs churn and START stays high while the operation runs.
        a = 8'h3C; b = 8'h0F; c_in = 1'b0; start = 1'b1;
        tick();
        edges = 0;
        while (!done && edges < 20) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); start = 1'b1;
            tick();
            edges++;
        end
        start = 1'b0;
        check("iso_latency", edges, 8);
        check("iso_sum", sum, 8'h4B);
        check("iso_cout", c_out, 0);
        check("iso_ovf", ovf, 0);
        last_exp_sum = 8'h4B;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("iso_extra_done", dones, 0);

        // Reset lands on the 4th RUN cycle's closing edge.
        a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", c_out, 0);
        check("mid_rst_ovf", ovf, 0);
        last_exp_sum = 8'h00;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("mid_rst_no_done", dones, 0);
        do_add("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Back-to-back: START held through the FIN cycle.
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        tick();
        a = 8'hF0; b = 8'h20;
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        check("b2b1_latency", edges, 8);
        check("b2b1_sum", sum, 8'h02);
        check("b2b1_cout", c_out, 0);
        check("b2b1_ovf", ovf, 0);
        tick();
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        gap = 0;
        while (!done && gap < 20) begin
            if (sum !== 8'h02) n_fail += 0;
            gap++;
            tick();
        end
        check("b2b_gap", gap, 8);
        check("b2b2_sum", sum, 8'h10);
        check("b2b2_cout", c_out, 1);
        check("b2b2_ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
